flit_input_buffer: RTL and testbench
====================================

Name: flit_input_buffer

Overview:
- Per-port input stage of the mesh router node. It sits directly between a link converter (producer of push_req/data_in) and the node controller/output muxes (consumers of data_out, packet_addr, pop_req).
- Buffers 16-bit flits in a first-word-fall-through FIFO.
- Tracks packet framing at the head of the queue, so the controller always sees the destination address of the packet currently being drained.
- Flit format: header flit = {length[15:8], dest_addr[7:0]}, followed by `length` body flits.

Parameters:
- DEPTH, 4, number of flit entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- push_req  input  1  upstream offers data_in this cycle.
- data_in  input  16  incoming flit.
- full  output  1  buffer cannot accept a push; fed back to the upstream link.
- pop_req  input  1  controller consumes the head flit this cycle.
- data_valid  output  1  buffer non-empty; data_out is valid.
- data_out  output  16  head flit (FWFT).
- packet_addr  output  8  destination address of the packet at the head.
- head_flit  output  1  the head entry is a packet header.
- last_flit  output  1  the head entry is the final flit of its packet.
- count  output  CNT_W  number of stored flits.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers = 0, count = 0, full = 0, data_valid = 0.
  - Framing state = HEAD, remaining = 0, latched address = 0.
  - All outputs read 0.
  - Reset mid-packet discards all contents and framing; the next pushed flit is treated as a header.
- Handshake:
  - pop_ok = pop_req & data_valid. A pop on empty is ignored.
  - push_ok = push_req & (!full | pop_ok). A push while full is accepted only if a pop occurs in the same cycle; otherwise it is dropped silently and state is unchanged.
  - count' = count + push_ok - pop_ok.
  - full = (count == DEPTH), data_valid = (count != 0); both are decoded from the registered count.
  - Simultaneous push and pop on empty: the pop is ignored, the push is accepted, and count becomes 1.
- Data path:
  - data_out = mem[rd_ptr] when data_valid, else 16'h0000.
  - Zero-cycle read latency: a flit pushed in cycle N is visible on data_out in cycle N+1.
  - Pointers wrap modulo DEPTH.
- Framing FSM (advances only on pop_ok):
  - HEAD:
    - Head entry is a header.
    - If data_out[15:8] == 0: stay in HEAD (single-flit packet).
    - Else: latch addr_q <= data_out[7:0], remaining <= data_out[15:8], go to BODY.
  - BODY:
    - remaining <= remaining - 1.
    - When remaining == 1 on a pop, go to HEAD.
    - remaining never underflows; length 255 is legal.
- Framing outputs (all gated by data_valid; 0 when empty):
  - packet_addr = data_out[7:0] in HEAD, addr_q in BODY.
  - head_flit = (state == HEAD).
  - last_flit = (HEAD & data_out[15:8] == 0) | (BODY & remaining == 1).
- The FSM holds its state while the buffer is empty mid-packet (BODY with count 0). packet_addr then reads 0 until the next body flit arrives, after which it shows addr_q again.
- No combinational path from push_req/data_in to any output. Only the framing outputs depend combinationally on registered state and the memory head.

Test Plan:
- Reset then idle: all outputs 0. Push a single flit with rst held low: count stays 0.
- Push 16'h0223, 16'hAAAA, 16'hBBBB, then pop one per cycle:
  - Cycle 1: head_flit = 1, last_flit = 0, packet_addr = 8'h23.
  - Cycle 2: head_flit = 0, last_flit = 0, packet_addr = 8'h23.
  - Cycle 3: last_flit = 1, packet_addr = 8'h23.
  - Then data_valid = 0 and the FSM is in HEAD.
- DEPTH = 4: push 5 flits with no pops; the 5th is dropped, full = 1, count = 4. Then push and pop in the same cycle: count stays 4, and the new flit appears at the tail (4th pop returns it).
- Push header 16'h0045: head_flit = 1, last_flit = 1, packet_addr = 8'h45. After the pop, the next header 16'h0112 shows packet_addr = 8'h12.
- Mid-packet starvation: push 16'h0267 and 1 body flit, pop both. Observe data_valid = 0 and packet_addr = 0. Push the 2nd body flit: packet_addr = 8'h67 and last_flit = 1.
- Reset asserted in BODY with count = 3: all outputs 0 immediately, without a clock edge. After release, push 16'h0099: head_flit = 1, packet_addr = 8'h99.

Source files
------------

// File: rtl/flit_input_buffer.sv
// flit_input_buffer
//   Per-port input stage of a mesh router node. Buffers 16-bit flits in a
//   first-word-fall-through FIFO and tracks packet framing at the head of the
//   queue, so the node controller always sees the destination of the packet
//   currently being drained.
//   Flit format: header = {length[15:8], dest_addr[7:0]}, then `length` bodies.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   push_req     upstream offers data_in this cycle
//   data_in      incoming flit
//   full         buffer cannot accept a push (unless a pop occurs this cycle)
//   pop_req      controller consumes the head flit this cycle
//   data_valid   buffer non-empty, data_out valid
//   data_out     head flit (zero when empty)
//   packet_addr  destination address of the packet at the head
//   head_flit    head entry is a packet header
//   last_flit    head entry is the final flit of its packet
//   count        number of stored flits
module flit_input_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_req,
   input  logic [15:0]      data_in,
   output logic             full,
   input  logic             pop_req,
   output logic             data_valid,
   output logic [15:0]      data_out,
   output logic [7:0]       packet_addr,
   output logic             head_flit,
   output logic             last_flit,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      HEAD = 1'b0,
      BODY = 1'b1
   } frame_state_t;

   logic [15:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      head;
   logic             push_ok;
   logic             pop_ok;

   frame_state_t     state;
   logic [7:0]       remaining;
   logic [7:0]       addr_q;

   assign full       = (cnt == CNT_W'(DEPTH));
   assign data_valid = (cnt != '0);
   assign count      = cnt;

   assign pop_ok  = pop_req & data_valid;
   // A push while full is only safe because the same-cycle pop frees a slot.
   assign push_ok = push_req & (~full | pop_ok);

   assign head     = mem[rd_ptr];
   assign data_out = data_valid ? head : '0;

   // Storage has no reset; data_out is gated by data_valid instead.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Framing tracker: advances only when a flit actually leaves the buffer,
   // so it simply holds in BODY while the queue is starved mid-packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= HEAD;
         remaining <= '0;
         addr_q    <= '0;
      end else if (pop_ok) begin
         case (state)
            HEAD: begin
               if (head[15:8] != 8'd0) begin
                  addr_q    <= head[7:0];
                  remaining <= head[15:8];
                  state     <= BODY;
               end
            end
            BODY: begin
               // remaining is >= 1 whenever in BODY, so this cannot underflow.
               remaining <= remaining - 8'd1;
               if (remaining == 8'd1) begin
                  state <= HEAD;
               end
            end
            default: state <= HEAD;
         endcase
      end
   end

   always_comb begin
      packet_addr = '0;
      head_flit   = 1'b0;
      last_flit   = 1'b0;
      if (data_valid) begin
         packet_addr = (state == HEAD) ? head[7:0] : addr_q;
         head_flit   = (state == HEAD);
         last_flit   = ((state == HEAD) && (head[15:8] == 8'd0)) ||
                       ((state == BODY) && (remaining == 8'd1));
      end
   end

endmodule

// File: tb/tb_flit_input_buffer.sv
module tb_flit_input_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             push_req = 1'b0;
   logic [15:0]      data_in = '0;
   logic             full;
   logic             pop_req = 1'b0;
   logic             data_valid;
   logic [15:0]      data_out;
   logic [7:0]       packet_addr;
   logic             head_flit;
   logic             last_flit;
   logic [CNT_W-1:0] count;

   int tests = 0;
   int fails = 0;

   flit_input_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .push_req    (push_req),
      .data_in     (data_in),
      .full        (full),
      .pop_req     (pop_req),
      .data_valid  (data_valid),
      .data_out    (data_out),
      .packet_addr (packet_addr),
      .head_flit   (head_flit),
      .last_flit   (last_flit),
      .count       (count)
   );

   always #5 clk = ~clk;

   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   task automatic do_push(input logic [15:0] d);
      push_req = 1'b1;
      data_in  = d;
      @(posedge clk); #1;
      push_req = 1'b0;
   endtask

   task automatic do_pop();
      pop_req = 1'b1;
      @(posedge clk); #1;
      pop_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      tests++; if ({full, data_valid, data_out, packet_addr, head_flit, last_flit, count} !== '0) begin
         fails++; $display("FAIL reset_idle outputs=%h expected 0",
                           {full, data_valid, data_out, packet_addr, head_flit, last_flit, count});
      end
      do_push(16'h1234);
      tests++; if (count !== 3'd0) begin
         fails++; $display("FAIL reset_push count=%0d expected 0", count);
      end
      tests++; if (data_valid !== 1'b0) begin
         fails++; $display("FAIL reset_push data_valid=%b expected 0", data_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_packet();
      do_push(16'h0223);
      do_push(16'hAAAA);
      do_push(16'hBBBB);
      tests++; if (count !== 3'd3) begin
         fails++; $display("FAIL pkt_count count=%0d expected 3", count);
      end
      tests++; if ({data_out, head_flit, last_flit, packet_addr} !== {16'h0223, 1'b1, 1'b0, 8'h23}) begin
         fails++; $display("FAIL pkt_c1 data=%h head=%b last=%b addr=%h expected 0223 1 0 23",
                           data_out, head_flit, last_flit, packet_addr);
      end
      do_pop();
      tests++; if ({data_out, head_flit, last_flit, packet_addr} !== {16'hAAAA, 1'b0, 1'b0, 8'h23}) begin
         fails++; $display("FAIL pkt_c2 data=%h head=%b last=%b addr=%h expected aaaa 0 0 23",
                           data_out, head_flit, last_flit, packet_addr);
      end
      do_pop();
      tests++; if ({data_out, head_flit, last_flit, packet_addr} !== {16'hBBBB, 1'b0, 1'b1, 8'h23}) begin
         fails++; $display("FAIL pkt_c3 data=%h head=%b last=%b addr=%h expected bbbb 0 1 23",
                           data_out, head_flit, last_flit, packet_addr);
      end
      do_pop();
      tests++; if ({data_valid, count, data_out} !== '0) begin
         fails++; $display("FAIL pkt_empty valid=%b count=%0d data=%h expected 0 0 0000",
                           data_valid, count, data_out);
      end
      // Back in HEAD: a fresh single-flit header must be flagged as header+last.
      do_push(16'h0031);
      tests++; if ({head_flit, last_flit, packet_addr} !== {1'b1, 1'b1, 8'h31}) begin
         fails++; $display("FAIL pkt_rehead head=%b last=%b addr=%h expected 1 1 31",
                           head_flit, last_flit, packet_addr);
      end
      do_pop();
   endtask

   task automatic test_full();
      for (int i = 1; i <= 5; i++) begin
         do_push(16'(i));
      end
      tests++; if ({full, count} !== {1'b1, 3'd4}) begin
         fails++; $display("FAIL full_drop full=%b count=%0d expected 1 4", full, count);
      end
      tests++; if (data_out !== 16'h0001) begin
         fails++; $display("FAIL full_head data=%h expected 0001", data_out);
      end
      // Push and pop together while full.
      push_req = 1'b1; data_in = 16'h0006; pop_req = 1'b1;
      @(posedge clk); #1;
      push_req = 1'b0; pop_req = 1'b0;
      tests++; if ({full, count} !== {1'b1, 3'd4}) begin
         fails++; $display("FAIL full_pushpop full=%b count=%0d expected 1 4", full, count);
      end
      tests++; if (data_out !== 16'h0002) begin
         fails++; $display("FAIL full_pop1 data=%h expected 0002", data_out);
      end
      do_pop();
      tests++; if (data_out !== 16'h0003) begin
         fails++; $display("FAIL full_pop2 data=%h expected 0003", data_out);
      end
      do_pop();
      tests++; if (data_out !== 16'h0004) begin
         fails++; $display("FAIL full_pop3 data=%h expected 0004", data_out);
      end
      do_pop();
      tests++; if ({data_out, count, full} !== {16'h0006, 3'd1, 1'b0}) begin
         fails++; $display("FAIL full_pop4 data=%h count=%0d full=%b expected 0006 1 0",
                           data_out, count, full);
      end
      do_pop();
      // Simultaneous push/pop on empty: pop ignored, push accepted.
      push_req = 1'b1; data_in = 16'h0077; pop_req = 1'b1;
      @(posedge clk); #1;
      push_req = 1'b0; pop_req = 1'b0;
      tests++; if ({count, data_out} !== {3'd1, 16'h0077}) begin
         fails++; $display("FAIL empty_pushpop count=%0d data=%h expected 1 0077", count, data_out);
      end
      do_pop();
      tests++; if (count !== 3'd0) begin
         fails++; $display("FAIL pop_empty count=%0d expected 0", count);
      end
      do_pop();
      tests++; if ({count, data_valid} !== {3'd0, 1'b0}) begin
         fails++; $display("FAIL pop_on_empty count=%0d valid=%b expected 0 0", count, data_valid);
      end
   endtask

   task automatic test_single_flit();
      do_push(16'h0045);
      do_push(16'h0112);
      tests++; if ({head_flit, last_flit, packet_addr} !== {1'b1, 1'b1, 8'h45}) begin
         fails++; $display("FAIL single_hdr head=%b last=%b addr=%h expected 1 1 45",
                           head_flit, last_flit, packet_addr);
      end
      do_pop();
      tests++; if ({head_flit, last_flit, packet_addr} !== {1'b1, 1'b0, 8'h12}) begin
         fails++; $display("FAIL next_hdr head=%b last=%b addr=%h expected 1 0 12",
                           head_flit, last_flit, packet_addr);
      end
      do_pop();
      do_push(16'hC0DE);
      tests++; if ({head_flit, last_flit, packet_addr} !== {1'b0, 1'b1, 8'h12}) begin
         fails++; $display("FAIL next_body head=%b last=%b addr=%h expected 0 1 12",
                           head_flit, last_flit, packet_addr);
      end
      do_pop();
   endtask

   task automatic test_starvation();
      do_push(16'h0267);
      do_push(16'h1111);
      do_pop();
      do_pop();
      tests++; if ({data_valid, packet_addr, head_flit, last_flit} !== '0) begin
         fails++; $display("FAIL starve_empty valid=%b addr=%h head=%b last=%b expected 0 00 0 0",
                           data_valid, packet_addr, head_flit, last_flit);
      end
      do_push(16'h2222);
      tests++; if ({packet_addr, last_flit, head_flit, data_out} !== {8'h67, 1'b1, 1'b0, 16'h2222}) begin
         fails++; $display("FAIL starve_resume addr=%h last=%b head=%b data=%h expected 67 1 0 2222",
                           packet_addr, last_flit, head_flit, data_out);
      end
      do_pop();
   endtask

   task automatic test_reset_mid_packet();
      do_push(16'h0301);
      do_push(16'hA001);
      do_push(16'hA002);
      do_push(16'hA003);
      do_pop();
      tests++; if ({count, head_flit, packet_addr} !== {3'd3, 1'b0, 8'h01}) begin
         fails++; $display("FAIL midpkt_setup count=%0d head=%b addr=%h expected 3 0 01",
                           count, head_flit, packet_addr);
      end
      #2 rst = 1'b0;
      #1;
      tests++; if ({full, data_valid, data_out, packet_addr, head_flit, last_flit, count} !== '0) begin
         fails++; $display("FAIL async_reset outputs=%h expected 0",
                           {full, data_valid, data_out, packet_addr, head_flit, last_flit, count});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_push(16'h0099);
      tests++; if ({head_flit, last_flit, packet_addr, count} !== {1'b1, 1'b1, 8'h99, 3'd1}) begin
         fails++; $display("FAIL post_reset head=%b last=%b addr=%h count=%0d expected 1 1 99 1",
                           head_flit, last_flit, packet_addr, count);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_packet();
      test_full();
      test_single_flit();
      test_starvation();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
